// File: rtl/axis_packet_splitter.sv
// rtl/axis_packet_splitter.sv - splits each input frame into fixed-length tlast-delimited sub-packets
// Optional macro: AXIS_PACKET_SPLITTER_TUSER_EN adds m_axis_tuser carrying the sub-packet index.
module axis_packet_splitter #(
  parameter int AXIS_TDATA_WIDTH     = 32,
  parameter int SUBPACKET_LENGTH     = 1024,
  parameter int PACKETS_PER_PACKET   = 4,
  parameter bit DISCARD_FIRST_PACKET = 1
) (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
`ifdef AXIS_PACKET_SPLITTER_TUSER_EN
  output logic [((PACKETS_PER_PACKET > 1) ? $clog2(PACKETS_PER_PACKET) : 1)-1:0] m_axis_tuser,
`endif
  output logic                        synced,
  output logic                        err_short,
  output logic                        err_long
);

  localparam int BW = (SUBPACKET_LENGTH > 1) ? $clog2(SUBPACKET_LENGTH) : 1;
  localparam int SW = (PACKETS_PER_PACKET > 1) ? $clog2(PACKETS_PER_PACKET) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(SUBPACKET_LENGTH - 1);
  localparam logic [SW-1:0] SUB_MAX  = SW'(PACKETS_PER_PACKET - 1);

  typedef enum logic {UNSYNC, RUN} state_t;

  state_t                      state_q, state_d;
  logic [BW-1:0]               beat_cnt, beat_d;
  logic [SW-1:0]               sub_cnt, sub_d;
  logic                        short_d, long_d;
  logic                        accept, push, push_last;
  logic                        drain_ok;
  logic                        skid_valid, skid_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0] skid_tdata;
  logic                        skid_tlast;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign drain_ok = ~m_axis_tvalid | m_axis_tready;
  assign synced   = (state_q == RUN);

  // State register: without discard mode the block trusts that reset lands on a frame boundary
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state_q <= DISCARD_FIRST_PACKET ? UNSYNC : RUN;
    else               state_q <= state_d;
  end

  // Next state, beat/sub-packet counting and frame-length error detection
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_cnt;
    sub_d     = sub_cnt;
    short_d   = 1'b0;
    long_d    = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      UNSYNC: begin
        if (accept && s_axis_tlast) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          push      = 1'b1;
          push_last = (beat_cnt == BEAT_MAX) | s_axis_tlast;
          if (s_axis_tlast) begin
            beat_d  = '0;
            sub_d   = '0;
            short_d = ~((beat_cnt == BEAT_MAX) && (sub_cnt == SUB_MAX));
          end else if (beat_cnt == BEAT_MAX) begin
            beat_d = '0;
            if (sub_cnt == SUB_MAX) begin
              sub_d  = '0;
              long_d = 1'b1;
            end else begin
              sub_d = sub_cnt + SW'(1);
            end
          end else begin
            beat_d = beat_cnt + BW'(1);
          end
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  // Skid occupancy after this cycle; only empty when output register is free or draining
  always_comb begin
    skid_valid_d = skid_valid;
    if (drain_ok) skid_valid_d = skid_valid & push;
    else          skid_valid_d = skid_valid | push;
  end

  // Counters and one-cycle error pulses
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      beat_cnt  <= '0;
      sub_cnt   <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      beat_cnt  <= beat_d;
      sub_cnt   <= sub_d;
      err_short <= short_d;
      err_long  <= long_d;
    end
  end

  // Two-entry output buffer: output register plus skid entry; ready is registered from skid occupancy
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      skid_valid    <= 1'b0;
      skid_tdata    <= '0;
      skid_tlast    <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= ~skid_valid_d;
      skid_valid    <= skid_valid_d;
      if (drain_ok) begin
        if (skid_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= skid_tdata;
          m_axis_tlast  <= skid_tlast;
        end else begin
          m_axis_tvalid <= push;
          if (push) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tlast <= push_last;
          end
        end
        if (skid_valid && push) begin
          skid_tdata <= s_axis_tdata;
          skid_tlast <= push_last;
        end
      end else if (push) begin
        skid_tdata <= s_axis_tdata;
        skid_tlast <= push_last;
      end
    end
  end

`ifdef AXIS_PACKET_SPLITTER_TUSER_EN
  logic [SW-1:0] skid_tuser;

  // Sub-packet index travels through the buffer alongside tdata
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis_tuser <= '0;
      skid_tuser   <= '0;
    end else if (drain_ok) begin
      if (skid_valid)  m_axis_tuser <= skid_tuser;
      else if (push)   m_axis_tuser <= sub_cnt;
      if (skid_valid && push) skid_tuser <= sub_cnt;
    end else if (push) begin
      skid_tuser <= sub_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_axis_packet_splitter.sv
// tb/tb_axis_packet_splitter.sv - directed self-checking bench for axis_packet_splitter (L=3, N=3, discard on)
module tb_axis_packet_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        synced, err_short, err_long;
`ifdef AXIS_PACKET_SPLITTER_TUSER_EN
  logic [1:0]  m_tuser;
`endif

  axis_packet_splitter #(
    .AXIS_TDATA_WIDTH(32), .SUBPACKET_LENGTH(3), .PACKETS_PER_PACKET(3), .DISCARD_FIRST_PACKET(1)
  ) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
`ifdef AXIS_PACKET_SPLITTER_TUSER_EN
    .m_axis_tuser(m_tuser),
`endif
    .synced(synced), .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc = 0, tx = 0, max_occ = 0, occ_viol = 0, stall_viol = 0, n_stall = 0;
  int n_short = 0, n_long = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_beat = '0;
  logic [63:0] out_beat;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          out_cyc[$];
  int          in_cyc[$];

`ifdef AXIS_PACKET_SPLITTER_TUSER_EN
  assign out_beat = {16'd0, 6'd0, m_tuser, 7'd0, m_tlast, m_tdata};
`else
  assign out_beat = {16'd0, 8'd0, 7'd0, m_tlast, m_tdata};
`endif

  // Cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle observer: records transfers, buffer occupancy, stall stability and error pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      acc        <= 0;
      tx         <= 0;
      prev_stall <= 1'b0;
    end else begin
      if ((acc - tx) > 2 || ((acc - tx) == 2 && s_tready) || (m_tvalid != ((acc - tx) > 0)))
        occ_viol <= occ_viol + 1;
      if ((acc - tx) > max_occ) max_occ <= acc - tx;
      if (prev_stall && (out_beat !== prev_beat)) stall_viol <= stall_viol + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_beat  <= out_beat;
      if (m_tvalid && !m_tready) n_stall <= n_stall + 1;
      if (m_tvalid && m_tready) begin
        got_q.push_back(out_beat);
        out_cyc.push_back(cyc);
        tx <= tx + 1;
      end
      if (s_tvalid && s_tready && synced) begin
        acc <= acc + 1;
        in_cyc.push_back(cyc);
      end
      if (err_short) n_short <= n_short + 1;
      if (err_long)  n_long  <= n_long + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", 64'(n >= 200), 64'd0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    @(negedge clk);
    while (m_tvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n >= 200), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic add_exp(input logic [31:0] d, input logic l, input logic [1:0] u);
    logic [63:0] v;
    v = 64'(d);
    v[32] = l;
`ifdef AXIS_PACKET_SPLITTER_TUSER_EN
    v[41:40] = u;
`endif
    exp_q.push_back(v);
  endtask

  // Nine-beat normal frame: tlast on every third beat, sub index = beat / 3
  task automatic add_frame(input logic [31:0] base);
    for (int i = 0; i < 9; i++) add_exp(base + 32'(i), (i % 3) == 2, 2'(i / 3));
  endtask

  task automatic cmp_stream(input string tag, input int base);
    check({tag, "_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (base + i) < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    int gb, ib, s0, l0;
    rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast",  64'(m_tlast),  64'd0);
    check("rst_m_tdata",  64'(m_tdata),  64'd0);
    check("rst_synced",   64'(synced),   64'd0);
    check("rst_errs",     64'({err_short, err_long}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_s_tready_pre", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_s_tready_post", 64'(s_tready), 64'd1);

    // Scenario 1: discard partial frame, then sparse traffic
    gb = got_q.size(); s0 = n_short; l0 = n_long;
    send(32'd2, 1'b0, 3);
    check("s1_synced_before", 64'(synced), 64'd0);
    send(32'd3, 1'b1, 3);
    check("s1_synced_after", 64'(synced), 64'd1);
    for (int i = 0; i < 9; i++) send(32'd11 + 32'(i), i == 8, 3);
    wait_drain("s1");
    add_frame(32'd11);
    cmp_stream("s1", gb);
    check("s1_err_short", 64'(n_short - s0), 64'd0);
    check("s1_err_long",  64'(n_long - l0),  64'd0);

    // Scenario 2: two back-to-back frames at full rate
    gb = got_q.size(); ib = in_cyc.size(); s0 = n_short; l0 = n_long;
    for (int i = 0; i < 9; i++) send(32'd101 + 32'(i), i == 8, 0);
    for (int i = 0; i < 9; i++) send(32'd111 + 32'(i), i == 8, 0);
    wait_drain("s2");
    add_frame(32'd101);
    add_frame(32'd111);
    cmp_stream("s2", gb);
    for (int i = 0; i < 18 && (gb + i) < out_cyc.size() && (ib + i) < in_cyc.size(); i++) begin
      check($sformatf("s2_latency%0d", i), 64'(out_cyc[gb + i] - in_cyc[ib + i]), 64'd1);
      if (i > 0) check($sformatf("s2_back2back%0d", i), 64'(out_cyc[gb + i] - out_cyc[gb + i - 1]), 64'd1);
    end
    check("s2_errs", 64'((n_short - s0) + (n_long - l0)), 64'd0);

    // Scenario 3: backpressure 1,0,0 repeating
    gb = got_q.size(); s0 = n_short; l0 = n_long;
    fork
      begin
        for (int i = 0; i < 9; i++) send(32'd201 + 32'(i), i == 8, 0);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          m_tready = (k % 3) == 0;
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    wait_drain("s3");
    add_frame(32'd201);
    cmp_stream("s3", gb);
    check("s3_stalls_seen",     64'(n_stall > 0), 64'd1);
    check("s3_stable_on_stall", 64'(stall_viol),  64'd0);
    check("s3_buffer_filled",   64'(max_occ),     64'd2);
    check("s3_ready_vs_occ",    64'(occ_viol),    64'd0);
    check("s3_errs", 64'((n_short - s0) + (n_long - l0)), 64'd0);

    // Scenario 4: five-beat short frame followed by a normal frame
    gb = got_q.size(); s0 = n_short; l0 = n_long;
    for (int i = 0; i < 5; i++) send(32'd31 + 32'(i), i == 4, 1);
    for (int i = 0; i < 9; i++) send(32'd41 + 32'(i), i == 8, 0);
    wait_drain("s4");
    add_exp(32'd31, 1'b0, 2'd0); add_exp(32'd32, 1'b0, 2'd0); add_exp(32'd33, 1'b1, 2'd0);
    add_exp(32'd34, 1'b0, 2'd1); add_exp(32'd35, 1'b1, 2'd1);
    add_frame(32'd41);
    cmp_stream("s4", gb);
    check("s4_err_short", 64'(n_short - s0), 64'd1);
    check("s4_err_long",  64'(n_long - l0),  64'd0);

    // Scenario 5: twelve-beat long frame, then reset in the middle of the next frame
    gb = got_q.size(); l0 = n_long;
    for (int i = 0; i < 12; i++) send(32'd51 + 32'(i), i == 11, 1);
    send(32'd71, 1'b0, 0);
    send(32'd72, 1'b0, 0);
    send(32'd73, 1'b0, 0);
    check("s5_valid_before_rst", 64'(m_tvalid), 64'd1);
    s_tdata = 32'd74; s_tvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("s5_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("s5_rst_m_tlast",  64'(m_tlast),  64'd0);
    check("s5_rst_synced",   64'(synced),   64'd0);
    check("s5_rst_s_tready", 64'(s_tready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) add_exp(32'd51 + 32'(i), (i % 3) == 2, 2'(i / 3));
    add_exp(32'd60, 1'b0, 2'd0); add_exp(32'd61, 1'b0, 2'd0); add_exp(32'd62, 1'b1, 2'd0);
    add_exp(32'd71, 1'b0, 2'd0); add_exp(32'd72, 1'b0, 2'd0);
    cmp_stream("s5a", gb);
    check("s5_err_long", 64'(n_long - l0), 64'd1);
    gb = got_q.size();
    send(32'd74, 1'b0, 0);
    send(32'd75, 1'b0, 0);
    check("s5_resync_before", 64'(synced), 64'd0);
    send(32'd76, 1'b1, 0);
    check("s5_resync_after", 64'(synced), 64'd1);
    for (int i = 0; i < 9; i++) send(32'd81 + 32'(i), i == 8, 0);
    wait_drain("s5");
    add_frame(32'd81);
    cmp_stream("s5b", gb);
    check("final_ready_vs_occ", 64'(occ_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
